// File: rtl/decode_stage_pkg.sv
// LC-3b shared types: opcodes, ALU operations and the packed decode control word.
package lc3b_types;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_SHF  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_xor  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  // alumux1_sel: 00 sr1, 01 pc+off9. alumux2_sel: 00 sr2, 01 off6, 10 imm4, 11 imm5.
  // regfile_mux_sel: 00 alu, 01 mem word, 10 mem byte, 11 pc. pcmux_sel: 00 off9, 01 off11, 10 sr1, 11 mem.
  typedef struct packed {
    logic       sr2_sel;
    logic       sh6_sel;
    logic       imm_sel;
    logic [1:0] alumux1_sel;
    logic [1:0] alumux2_sel;
    lc3b_aluop  alu_ctrl;
    logic       indirect;
    logic       read;
    logic       write;
    logic       mem_byte;
    logic       load_regfile;
    logic [1:0] regfile_mux_sel;
    logic       load_cc;
    logic       destmux_sel;
    logic [1:0] pcmux_sel;
  } lc3b_ctrl_word;

endpackage

// File: rtl/decode_stage_logic.sv
// Combinational LC-3b instruction decoder: control word, register fields, source usage.
module decode_logic
  import lc3b_types::*;
(
  input  logic          [15:0] instr,
  output lc3b_ctrl_word        ctrl,
  output logic          [2:0]  sr1,
  output logic          [2:0]  sr2,
  output logic          [2:0]  dest,
  output logic                 uses_sr1,
  output logic                 uses_sr2,
  output logic                 is_load,
  output logic                 illegal
);

  logic [3:0] op;
  assign op = instr[15:12];

  always_comb begin
    ctrl     = '0;
    sr1      = instr[8:6];
    sr2      = 3'd0;
    dest     = instr[11:9];
    uses_sr1 = 1'b0;
    uses_sr2 = 1'b0;
    is_load  = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD, OP_AND, OP_XOR: begin
        uses_sr1          = 1'b1;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
        ctrl.imm_sel      = instr[5];
        ctrl.alumux2_sel  = instr[5] ? 2'b11 : 2'b00;
        ctrl.alu_ctrl     = (op == OP_ADD) ? alu_add : (op == OP_AND) ? alu_and : alu_xor;
        if (!instr[5]) begin
          uses_sr2 = 1'b1;
          sr2      = instr[2:0];
        end
      end
      OP_SHF: begin
        uses_sr1          = 1'b1;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
        ctrl.sh6_sel      = 1'b1;
        ctrl.alumux2_sel  = 2'b10;
        ctrl.alu_ctrl     = !instr[4] ? alu_sll : (instr[5] ? alu_sra : alu_srl);
      end
      OP_LDR, OP_LDB, OP_LDI: begin
        uses_sr1             = 1'b1;
        is_load              = 1'b1;
        ctrl.read            = 1'b1;
        ctrl.load_regfile    = 1'b1;
        ctrl.load_cc         = 1'b1;
        ctrl.alumux2_sel     = 2'b01;
        ctrl.mem_byte        = (op == OP_LDB);
        ctrl.indirect        = (op == OP_LDI);
        ctrl.regfile_mux_sel = (op == OP_LDB) ? 2'b10 : 2'b01;
      end
      OP_STR, OP_STB, OP_STI: begin
        // Store data travels on the sr2 port so both sources get hazard-checked.
        uses_sr1         = 1'b1;
        uses_sr2         = 1'b1;
        sr2              = instr[11:9];
        ctrl.sr2_sel     = 1'b1;
        ctrl.write       = 1'b1;
        ctrl.alumux2_sel = 2'b01;
        ctrl.mem_byte    = (op == OP_STB);
        ctrl.indirect    = (op == OP_STI);
        ctrl.read        = (op == OP_STI);
      end
      OP_LEA: begin
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
        ctrl.alumux1_sel  = 2'b01;
        ctrl.alu_ctrl     = alu_pass;
      end
      OP_BR: ;
      OP_JMP: begin
        uses_sr1       = 1'b1;
        ctrl.pcmux_sel = 2'b10;
      end
      OP_JSR: begin
        dest                 = 3'd7;
        ctrl.load_regfile    = 1'b1;
        ctrl.regfile_mux_sel = 2'b11;
        ctrl.destmux_sel     = 1'b1;
        uses_sr1             = !instr[11];
        ctrl.pcmux_sel       = instr[11] ? 2'b01 : 2'b10;
      end
      OP_TRAP: begin
        dest                 = 3'd7;
        ctrl.read            = 1'b1;
        ctrl.load_regfile    = 1'b1;
        ctrl.regfile_mux_sel = 2'b11;
        ctrl.destmux_sel     = 1'b1;
        ctrl.pcmux_sel       = 2'b11;
      end
      default: illegal = 1'b1;  // RTI
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, load-use stall and stall counter.
module decode_stage
  import lc3b_types::*;
#(
  parameter int PC_W      = 16,
  parameter int NUM_REGS  = 8,
  parameter int HAZ_DEPTH = 1,
  parameter int CNT_W     = 32,
  localparam int REG_W    = $clog2(NUM_REGS),
  localparam int CTRL_W   = $bits(lc3b_ctrl_word)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_W-1:0]  out_sr1,
  output logic [REG_W-1:0]  out_sr2,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  stall_count
);

  lc3b_ctrl_word dl_ctrl;
  logic [2:0]    dl_sr1, dl_sr2, dl_dest;
  logic          dl_uses_sr1, dl_uses_sr2, dl_is_load, dl_illegal;

  decode_logic u_dec (
    .instr   (in_instr),
    .ctrl    (dl_ctrl),
    .sr1     (dl_sr1),
    .sr2     (dl_sr2),
    .dest    (dl_dest),
    .uses_sr1(dl_uses_sr1),
    .uses_sr2(dl_uses_sr2),
    .is_load (dl_is_load),
    .illegal (dl_illegal)
  );

  logic                  out_valid_q, out_valid_d;
  logic [15:0]           out_instr_q, out_instr_d;
  logic [PC_W-1:0]       out_pc_q, out_pc_d;
  logic [CTRL_W-1:0]     out_ctrl_q, out_ctrl_d;
  logic [REG_W-1:0]      out_sr1_q, out_sr1_d, out_sr2_q, out_sr2_d, out_dest_q, out_dest_d;
  logic                  out_illegal_q, out_illegal_d, is_load_q, is_load_d;
  logic [CNT_W-1:0]      stall_q, stall_d;
  logic [HAZ_DEPTH-1:0]             trk_vld_q, trk_vld_d;
  logic [HAZ_DEPTH-1:0][REG_W-1:0]  trk_dest_q, trk_dest_d;

  logic [REG_W-1:0] src1, src2;
  logic             match1, match2, hazard, fire_in, fire_out;

  assign src1 = REG_W'(dl_sr1);
  assign src2 = REG_W'(dl_sr2);

  always_comb begin
    match1 = out_valid_q & is_load_q & (out_dest_q == src1);
    match2 = out_valid_q & is_load_q & (out_dest_q == src2);
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      match1 = match1 | (trk_vld_q[i] & (trk_dest_q[i] == src1));
      match2 = match2 | (trk_vld_q[i] & (trk_dest_q[i] == src2));
    end
    hazard = in_valid & ((dl_uses_sr1 & match1) | (dl_uses_sr2 & match2));
  end

  assign in_ready = (!out_valid_q | out_ready) & !hazard & !flush;
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid_q & out_ready;

  always_comb begin
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_ctrl_d    = out_ctrl_q;
    out_sr1_d     = out_sr1_q;
    out_sr2_d     = out_sr2_q;
    out_dest_d    = out_dest_q;
    out_illegal_d = out_illegal_q;
    is_load_d     = is_load_q;
    out_valid_d   = out_valid_q;
    if (flush)         out_valid_d = 1'b0;
    else if (fire_in)  out_valid_d = 1'b1;
    else if (fire_out) out_valid_d = 1'b0;
    if (fire_in) begin
      out_instr_d   = in_instr;
      out_pc_d      = in_pc;
      out_ctrl_d    = dl_ctrl;
      out_sr1_d     = src1;
      out_sr2_d     = src2;
      out_dest_d    = REG_W'(dl_dest);
      out_illegal_d = dl_illegal;
      is_load_d     = dl_is_load;
    end
    stall_d = stall_q;
    if (hazard && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
  end

  // A flushed payload never reaches EX, so the tracker neither records it nor ages.
  always_comb begin
    trk_vld_d  = trk_vld_q;
    trk_dest_d = trk_dest_q;
    if (out_ready && !flush) begin
      trk_vld_d[0]  = fire_out & is_load_q;
      trk_dest_d[0] = out_dest_q;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        trk_vld_d[i]  = trk_vld_q[i-1];
        trk_dest_d[i] = trk_dest_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      out_ctrl_q    <= '0;
      out_sr1_q     <= '0;
      out_sr2_q     <= '0;
      out_dest_q    <= '0;
      out_illegal_q <= 1'b0;
      is_load_q     <= 1'b0;
      stall_q       <= '0;
      trk_vld_q     <= '0;
      trk_dest_q    <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_ctrl_q    <= out_ctrl_d;
      out_sr1_q     <= out_sr1_d;
      out_sr2_q     <= out_sr2_d;
      out_dest_q    <= out_dest_d;
      out_illegal_q <= out_illegal_d;
      is_load_q     <= is_load_d;
      stall_q       <= stall_d;
      trk_vld_q     <= trk_vld_d;
      trk_dest_q    <= trk_dest_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_sr1     = out_sr1_q;
  assign out_sr2     = out_sr2_q;
  assign out_dest    = out_dest_q;
  assign out_illegal = out_illegal_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, load-use stalls, backpressure, flush, decode fields.
module tb_decode_stage;
  import lc3b_types::*;

  localparam int PC_W   = 16;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 32;
  localparam int CTRL_W = $bits(lc3b_ctrl_word);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready, flush = 1'b0;
  logic [15:0]       in_instr = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic              out_valid, out_ready = 1'b1, out_illegal;
  logic [15:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_W-1:0]  out_sr1, out_sr2, out_dest;
  logic [CNT_W-1:0]  stall_count;
  lc3b_ctrl_word     c;

  int n_chk = 0;
  int n_fail = 0;

  assign c = lc3b_ctrl_word'(out_ctrl);

  always #5 clk = ~clk;

  decode_stage #(.PC_W(PC_W), .NUM_REGS(8), .HAZ_DEPTH(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl),
    .out_sr1(out_sr1), .out_sr2(out_sr2), .out_dest(out_dest),
    .out_illegal(out_illegal), .stall_count(stall_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic test_reset();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
    n_chk++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL rst_out_ctrl got %0h want 0", out_ctrl); end
    n_chk++; if (out_instr !== 16'h0) begin n_fail++; $display("FAIL rst_out_instr got %0h want 0", out_instr); end
    rst_n = 1'b1;
    step();
    drive(1, 16'h6640, 1, 0); in_pc = 16'h0100;
    step();
    drive(1, 16'h18C3, 1, 0);
    step();
    n_chk++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL pre_rst_stall got %0d want 1", stall_count); end
    drive(1, 16'h18C3, 0, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %0h want 0", out_valid); end
    n_chk++; if (stall_count !== '0) begin n_fail++; $display("FAIL async_rst_stall got %0d want 0", stall_count); end
    #1 rst_n = 1'b1;
    drive(1, 16'h12A5, 1, 0); in_pc = 16'h3000;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0h want 1", out_valid); end
    n_chk++; if (out_dest !== 3'd1) begin n_fail++; $display("FAIL add_dest got %0d want 1", out_dest); end
    n_chk++; if (out_sr1 !== 3'd2) begin n_fail++; $display("FAIL add_sr1 got %0d want 2", out_sr1); end
    n_chk++; if (out_pc !== 16'h3000) begin n_fail++; $display("FAIL add_pc got %0h want 3000", out_pc); end
    n_chk++; if (c.alumux2_sel !== 2'b11) begin n_fail++; $display("FAIL add_alumux2 got %0b want 11", c.alumux2_sel); end
    n_chk++; if (c.alu_ctrl !== alu_add) begin n_fail++; $display("FAIL add_aluop got %0d want %0d", c.alu_ctrl, alu_add); end
    n_chk++; if (c.load_cc !== 1'b1) begin n_fail++; $display("FAIL add_load_cc got %0b want 1", c.load_cc); end
    n_chk++; if (c.imm_sel !== 1'b1) begin n_fail++; $display("FAIL add_imm_sel got %0b want 1", c.imm_sel); end
    drive(0, 16'h0, 1, 0);
    step();
  endtask

  task automatic test_load_use();
    drive(1, 16'h6640, 1, 0);
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ldr_ready got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_dest !== 3'd3) begin n_fail++; $display("FAIL lu_ldr_dest got %0d want 3", out_dest); end
    n_chk++; if (c.regfile_mux_sel !== 2'b01 || c.read !== 1'b1) begin n_fail++; $display("FAIL lu_ldr_ctrl got %0h", out_ctrl); end
    drive(1, 16'h18C3, 1, 0);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall1 got %0h want 0", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %0h want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall2 got %0h want 0", in_ready); end
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_release got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 16'h18C3) begin n_fail++; $display("FAIL lu_issue got v=%0h i=%0h want 1/18c3", out_valid, out_instr); end
    n_chk++; if (out_dest !== 3'd4 || out_sr1 !== 3'd3 || out_sr2 !== 3'd3) begin n_fail++; $display("FAIL lu_fields got d=%0d s1=%0d s2=%0d want 4/3/3", out_dest, out_sr1, out_sr2); end
    n_chk++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL lu_stall_count got %0d want 2", stall_count); end
    drive(0, 16'h0, 1, 0);
    step();
  endtask

  task automatic test_no_hazard();
    rst_n = 1'b0; #1 rst_n = 1'b1;
    drive(1, 16'h6640, 1, 0);
    step();
    drive(1, 16'h1285, 1, 0);
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nh_ready got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_instr !== 16'h1285 || out_sr2 !== 3'd5) begin n_fail++; $display("FAIL nh_issue got i=%0h s2=%0d want 1285/5", out_instr, out_sr2); end
    n_chk++; if (stall_count !== '0) begin n_fail++; $display("FAIL nh_stall got %0d want 0", stall_count); end
    drive(0, 16'h0, 1, 0);
    step();
    step();
  endtask

  task automatic test_backpressure();
    drive(1, 16'hB640, 0, 0);
    step();
    drive(1, 16'h1285, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %0h want 0", k, in_ready); end
      n_chk++; if (out_valid !== 1'b1 || out_instr !== 16'hB640) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%0h i=%0h want 1/b640", k, out_valid, out_instr); end
      n_chk++; if (c.indirect !== 1'b1 || c.write !== 1'b1 || c.read !== 1'b1 || c.sr2_sel !== 1'b1) begin n_fail++; $display("FAIL bp_ctrl[%0d] got %0h", k, out_ctrl); end
      n_chk++; if (out_sr2 !== 3'd3 || out_sr1 !== 3'd1) begin n_fail++; $display("FAIL bp_regs[%0d] got s1=%0d s2=%0d want 1/3", k, out_sr1, out_sr2); end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 16'h1285) begin n_fail++; $display("FAIL bp_next got v=%0h i=%0h want 1/1285", out_valid, out_instr); end
    n_chk++; if (stall_count !== '0) begin n_fail++; $display("FAIL bp_stall got %0d want 0", stall_count); end
    drive(0, 16'h0, 1, 0);
    step();
  endtask

  task automatic test_flush();
    drive(1, 16'h6640, 1, 0);
    step();
    drive(1, 16'h1285, 1, 0);
    step();
    drive(1, 16'h5285, 0, 1);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %0h want 0", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %0h want 0", out_valid); end
    n_chk++; if (out_instr !== 16'h1285) begin n_fail++; $display("FAIL fl_dropped got %0h want 1285", out_instr); end
    drive(1, 16'h18C3, 0, 0);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_tracker_kept got %0h want 0", in_ready); end
    step();
    drive(1, 16'h18C3, 1, 0);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_tracker_age got %0h want 0", in_ready); end
    step();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_release got %0h want 1", in_ready); end
    step();
    n_chk++; if (out_valid !== 1'b1 || out_instr !== 16'h18C3) begin n_fail++; $display("FAIL fl_issue got v=%0h i=%0h want 1/18c3", out_valid, out_instr); end
    n_chk++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL fl_stall got %0d want 2", stall_count); end
    drive(0, 16'h0, 1, 0);
    step();
  endtask

  task automatic test_decode();
    drive(1, 16'h8000, 1, 0);
    step();
    n_chk++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL rti_illegal got %0h want 1", out_illegal); end
    n_chk++; if (out_ctrl !== '0 || c.load_regfile !== 1'b0) begin n_fail++; $display("FAIL rti_ctrl got %0h want 0", out_ctrl); end
    drive(1, 16'hF025, 1, 0);
    step();
    n_chk++; if (out_illegal !== 1'b0 || out_dest !== 3'd7) begin n_fail++; $display("FAIL trap_dest got ill=%0h d=%0d want 0/7", out_illegal, out_dest); end
    n_chk++; if (c.read !== 1'b1 || c.regfile_mux_sel !== 2'b11 || c.destmux_sel !== 1'b1 || c.pcmux_sel !== 2'b11) begin n_fail++; $display("FAIL trap_ctrl got %0h", out_ctrl); end
    drive(1, 16'hD6D2, 1, 0);
    step();
    n_chk++; if (c.alu_ctrl !== alu_srl || c.sh6_sel !== 1'b1 || c.alumux2_sel !== 2'b10) begin n_fail++; $display("FAIL shf_ctrl got %0h", out_ctrl); end
    n_chk++; if (out_dest !== 3'd3 || c.load_cc !== 1'b1) begin n_fail++; $display("FAIL shf_dest got d=%0d cc=%0b want 3/1", out_dest, c.load_cc); end
    drive(1, 16'h3640, 1, 0);
    step();
    n_chk++; if (out_sr2 !== 3'd3 || c.sr2_sel !== 1'b1 || c.write !== 1'b1 || c.mem_byte !== 1'b1 || c.load_regfile !== 1'b0) begin n_fail++; $display("FAIL stb_ctrl got s2=%0d ctrl=%0h", out_sr2, out_ctrl); end
    drive(1, 16'h4800, 1, 0);
    step();
    n_chk++; if (out_dest !== 3'd7 || c.pcmux_sel !== 2'b01 || c.load_regfile !== 1'b1) begin n_fail++; $display("FAIL jsr_ctrl got d=%0d ctrl=%0h", out_dest, out_ctrl); end
    drive(1, 16'h2640, 1, 0);
    step();
    n_chk++; if (c.mem_byte !== 1'b1 || c.regfile_mux_sel !== 2'b10 || c.read !== 1'b1 || c.write !== 1'b0) begin n_fail++; $display("FAIL ldb_ctrl got %0h", out_ctrl); end
    drive(0, 16'h0, 1, 0);
    step();
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_backpressure();
    test_flush();
    test_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
